dense_layer_mac: RTL and testbench
==================================

# dense_layer_mac

Parametrised fully-connected MLP layer: accepts an N_IN-element signed fixed-point input vector via valid/ready, computes N_OUT neuron outputs with LANES parallel multiply-accumulate units, adds biases, saturates, applies a selectable activation, and presents the result vector via valid/ready. It is the next-generation layer primitive for the MLP datapath. Layers chain output-to-input, and weights and biases can be written at runtime or preloaded by the bench through the `weights`/`biases` arrays.

## Interface
- N_OUT, 4, neurons in the layer
- N_IN, 10, inputs per neuron
- LANES, 2, parallel MAC lanes (1..N_OUT)
- DATA_W, 32, signed data/weight/bias width
- FRAC, 16, fractional bits (Q(DATA_W-FRAC).FRAC)
- ACT, 0, activation: 0 none, 1 ReLU, 2 leaky ReLU (slope 1/8); other values treated as 0
- CLK  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  compute enable; low freezes the state machine and all counters
- inputs  in  DATA_W x N_IN  input vector, sampled on accept
- in_valid  in  1  input vector valid
- in_ready  out  1  layer can accept a vector
- out  out  DATA_W x N_OUT  result vector, registered
- out_valid  out  1  result held valid
- out_ready  in  1  consumer takes result
- end_layer  out  1  one-cycle pulse when out_valid rises
- w_we  in  1  weight/bias write strobe
- w_addr  in  clog2(N_OUT*N_IN+N_OUT)  address: 0..N_OUT*N_IN-1 weights, then N_OUT biases
- w_data  in  DATA_W  write data

## Operation
- Storage: `weights[n*N_IN+i]` is neuron n, input i; `biases[n]`. Neither array is affected by reset.
- Writes: accepted on the w_we edge only in IDLE or DONE. Dropped when busy or when the address is out of range.
- States:
  - IDLE: in_ready = enable. Accept on in_valid&&in_ready: latch inputs, group=0, idx=0, accumulators=0, go to MAC.
  - MAC: each enabled cycle, lane l (neuron n = group*LANES+l) does acc_l += weights[n*N_IN+idx]*x[idx]; idx++. After idx = N_IN-1, go to WB.
  - WB: for each lane with n < N_OUT, compute out[n] = act(sat((acc_l + (biases[n] <<< FRAC)) >>> FRAC)). Clear accumulators and idx. If last group, go to DONE; otherwise group++ and return to MAC. Lanes with n ≥ N_OUT (partial last group) are masked and write nothing.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Arithmetic:
  - Accumulator width is 2*DATA_W+clog2(N_IN)+1, so there is no internal overflow.
  - >>> is arithmetic shift (truncation toward −inf).
  - sat clamps to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - ReLU: y<0 → 0.
  - Leaky ReLU: y<0 → y>>>3, applied after saturation.
- enable low in any state: no state, counter, accumulator or output change. in_ready=0 while enable is low.
- out holds its last value until overwritten by the next computation's WB.

## Timing
- Reset values: out all 0, out_valid 0, end_layer 0, in_ready 1 once enable is high, state IDLE, counters and accumulators 0.
- Reset is asynchronous and clears immediately, including mid-MAC. The stored result is lost and weights are retained.
- Latency: out_valid rises G*(N_IN+1) enabled edges after the accept edge, with G = ceil(N_OUT/LANES). Default parameters give 22 edges.
- Stall cycles (enable low) add one-for-one to latency.
- end_layer pulses high for exactly the first cycle out_valid is high.
- Handshake: in_ready is low from the accept edge until the edge after out_ready is seen in DONE. A new vector can be accepted at the earliest one cycle after the result handshake. There is no overlap between result presentation and the next computation.
- in_valid while in_ready=0 is ignored; the producer must hold it.

## Test plan
- Basic: all weights 0x00010000, inputs 0x00010000, biases 0, ACT=0 → every out = 0x000A0000. out_valid rises 22 edges after accept, end_layer pulses once.
- Activation: same weights and inputs, biases 0xFFEC0000 (−20.0) → ACT=0 gives 0xFFF60000, ACT=1 gives 0x00000000, ACT=2 gives 0xFFFEC000.
- Saturation: weights and inputs 0x7FFF0000, bias 0 → out 0x7FFFFFFF. Negate the inputs → out 0x80000000.
- Stall/reset: enable low for 7 cycles mid-MAC → out_valid at edge 29 with correct values. Reset at MAC edge 5 → out 0, out_valid 0, in_ready 1. A rerun then gives the basic result with preloaded weights intact.
- Writes: w_we to weights[0] during MAC is ignored (result unchanged). The same write in IDLE with w_data 0x00020000 → out[0]=0x000B0000. A write to address 44 has no effect.
- Partial group: N_OUT=3, LANES=2, basic stimulus → out[0..2]=0x000A0000, latency 22, masked lane writes nothing.

Source files
------------

// File: rtl/dense_layer_mac_if.sv
// Bus bundle for dense_layer_mac: input vector, result vector, compute enable
// and the weight/bias write port.
interface dense_layer_mac_if #(
   parameter int N_OUT  = 4,
   parameter int N_IN   = 10,
   parameter int DATA_W = 32
);
   localparam int AW = $clog2(N_OUT * N_IN + N_OUT);

   // valid/ready: a transfer happens on a rising edge where valid && ready are
   // both high; the producer holds valid and data stable until that edge, and
   // ready may depend on state and enable but never on valid.
   logic                           enable;
   logic [N_IN-1:0][DATA_W-1:0]    inputs;
   logic                           in_valid;
   logic                           in_ready;
   logic [N_OUT-1:0][DATA_W-1:0]   out;
   logic                           out_valid;
   logic                           out_ready;
   logic                           end_layer;
   logic                           w_we;
   logic [AW-1:0]                  w_addr;
   logic [DATA_W-1:0]              w_data;

   modport master (
      output enable, inputs, in_valid, out_ready, w_we, w_addr, w_data,
      input  in_ready, out, out_valid, end_layer
   );

   modport slave (
      input  enable, inputs, in_valid, out_ready, w_we, w_addr, w_data,
      output in_ready, out, out_valid, end_layer
   );
endinterface

// File: rtl/dense_layer_mac.sv
// Fully-connected layer: LANES MAC units walk the neurons group by group,
// then bias, saturate and activate each neuron into a registered result vector.
module dense_layer_mac #(
   parameter int N_OUT  = 4,
   parameter int N_IN   = 10,
   parameter int LANES  = 2,
   parameter int DATA_W = 32,
   parameter int FRAC   = 16,
   parameter int ACT    = 0
) (
   input  logic               CLK,
   input  logic               reset,
   dense_layer_mac_if.slave   bus,
   output logic [1:0]         state_dbg
);
   localparam int G     = (N_OUT + LANES - 1) / LANES;
   localparam int GW    = (G > 1) ? $clog2(G) : 1;
   localparam int IW    = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int ACC_W = 2 * DATA_W + $clog2(N_IN) + 1;
   localparam int N_W   = N_OUT * N_IN;
   localparam int AW    = $clog2(N_W + N_OUT);
   localparam int WIW   = (N_W > 1) ? $clog2(N_W) : 1;
   localparam int BIW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_t;

   state_t                    state, state_nx;
   logic signed [DATA_W-1:0]  weights [N_W];
   logic signed [DATA_W-1:0]  biases  [N_OUT];
   logic signed [DATA_W-1:0]  x       [N_IN];
   logic signed [ACC_W-1:0]   acc     [LANES];
   logic signed [ACC_W-1:0]   acc_mac [LANES];
   logic signed [ACC_W-1:0]   shifted [LANES];
   logic signed [DATA_W-1:0]  w_cur   [LANES];
   logic signed [DATA_W-1:0]  b_cur   [LANES];
   logic signed [DATA_W-1:0]  sat_v   [LANES];
   logic signed [DATA_W-1:0]  res     [LANES];
   logic signed [2*DATA_W-1:0] prod   [LANES];
   int                        lane_n  [LANES];
   logic                      lane_on [LANES];
   logic [GW-1:0]             group;
   logic [IW-1:0]             idx;
   logic                      last_idx, last_group, accept;

   function automatic logic signed [DATA_W-1:0] activate(input logic signed [DATA_W-1:0] y);
      case (ACT)
         1:       return y[DATA_W-1] ? '0 : y;
         2:       return y[DATA_W-1] ? (y >>> 3) : y;
         default: return y;
      endcase
   endfunction

   assign last_idx      = (idx == IW'(N_IN - 1));
   assign last_group    = (group == GW'(G - 1));
   assign bus.out_valid = (state == DONE);
   assign state_dbg     = state;

   always_comb begin
      state_nx     = state;
      accept       = 1'b0;
      bus.in_ready = 1'b0;
      if (bus.enable) begin
         case (state)
            IDLE: begin
               bus.in_ready = 1'b1;
               if (bus.in_valid) begin
                  accept   = 1'b1;
                  state_nx = MAC;
               end
            end
            MAC:     if (last_idx) state_nx = WB;
            WB:      state_nx = last_group ? DONE : MAC;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   // Lanes past N_OUT in a partial last group keep a zero accumulator.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         lane_n[l]  = int'(group) * LANES + l;
         lane_on[l] = (lane_n[l] < N_OUT);
         w_cur[l]   = weights[WIW'(lane_on[l] ? lane_n[l] * N_IN + int'(idx) : 0)];
         b_cur[l]   = biases[BIW'(lane_on[l] ? lane_n[l] : 0)];
         prod[l]    = (2*DATA_W)'(w_cur[l]) * (2*DATA_W)'(x[idx]);
         acc_mac[l] = lane_on[l] ? acc[l] + ACC_W'(prod[l]) : acc[l];
         shifted[l] = (acc[l] + (ACC_W'(b_cur[l]) <<< FRAC)) >>> FRAC;
         if (shifted[l] > SAT_MAX)      sat_v[l] = SAT_MAX[DATA_W-1:0];
         else if (shifted[l] < SAT_MIN) sat_v[l] = SAT_MIN[DATA_W-1:0];
         else                           sat_v[l] = shifted[l][DATA_W-1:0];
         res[l]     = activate(sat_v[l]);
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         group         <= '0;
         idx           <= '0;
         bus.out       <= '0;
         bus.end_layer <= 1'b0;
         for (int l = 0; l < LANES; l++) acc[l] <= '0;
         for (int i = 0; i < N_IN; i++) x[i] <= '0;
      end else begin
         bus.end_layer <= bus.enable && (state == WB) && last_group;
         if (bus.enable) begin
            state <= state_nx;
            case (state)
               IDLE: if (accept) begin
                  group <= '0;
                  idx   <= '0;
                  for (int i = 0; i < N_IN; i++) x[i] <= bus.inputs[i];
                  for (int l = 0; l < LANES; l++) acc[l] <= '0;
               end
               MAC: begin
                  for (int l = 0; l < LANES; l++) acc[l] <= acc_mac[l];
                  if (!last_idx) idx <= idx + 1'b1;
               end
               WB: begin
                  for (int n = 0; n < N_OUT; n++)
                     if (group == GW'(n / LANES)) bus.out[n] <= res[n % LANES];
                  for (int l = 0; l < LANES; l++) acc[l] <= '0;
                  idx <= '0;
                  if (!last_group) group <= group + 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   // Coefficient memory has no reset so preloaded weights survive a layer reset.
   always_ff @(posedge CLK) begin
      if (bus.w_we && (state == IDLE || state == DONE)) begin
         if (bus.w_addr < AW'(N_W))
            weights[bus.w_addr[WIW-1:0]] <= bus.w_data;
         else if (bus.w_addr < AW'(N_W + N_OUT))
            biases[BIW'(bus.w_addr - AW'(N_W))] <= bus.w_data;
      end
   end
endmodule

// File: tb/tb_dense_layer_mac.sv
// Directed bench for dense_layer_mac: four instances (ACT 0/1/2 and a partial
// last group) run the same vectors in lockstep against hand-computed results.
module tb_dense_layer_mac;
   localparam int N_IN = 10;
   localparam int DW   = 32;

   typedef struct {
      logic [DW-1:0] w, b, x;
      logic [DW-1:0] e0, e1, e2;
   } vec_t;

   logic                     CLK = 1'b0;
   logic                     reset;
   logic                     enable, in_valid, out_ready, w_we, w_we3;
   logic [5:0]               w_addr, w_addr3;
   logic [DW-1:0]            w_data;
   logic [N_IN-1:0][DW-1:0]  inputs_v;
   logic [1:0]               st0, st1, st2, st3;
   int                       checks = 0;
   int                       errors = 0;
   vec_t                     tbl [7];

   always #5 CLK = ~CLK;

   dense_layer_mac_if #(.N_OUT(4), .N_IN(N_IN), .DATA_W(DW)) if0 ();
   dense_layer_mac_if #(.N_OUT(4), .N_IN(N_IN), .DATA_W(DW)) if1 ();
   dense_layer_mac_if #(.N_OUT(4), .N_IN(N_IN), .DATA_W(DW)) if2 ();
   dense_layer_mac_if #(.N_OUT(3), .N_IN(N_IN), .DATA_W(DW)) if3 ();

   assign {if0.enable, if0.in_valid, if0.out_ready, if0.w_we, if0.w_addr} = {enable, in_valid, out_ready, w_we, w_addr};
   assign {if1.enable, if1.in_valid, if1.out_ready, if1.w_we, if1.w_addr} = {enable, in_valid, out_ready, w_we, w_addr};
   assign {if2.enable, if2.in_valid, if2.out_ready, if2.w_we, if2.w_addr} = {enable, in_valid, out_ready, w_we, w_addr};
   assign {if3.enable, if3.in_valid, if3.out_ready, if3.w_we, if3.w_addr} = {enable, in_valid, out_ready, w_we3, w_addr3};
   assign {if0.inputs, if0.w_data} = {inputs_v, w_data};
   assign {if1.inputs, if1.w_data} = {inputs_v, w_data};
   assign {if2.inputs, if2.w_data} = {inputs_v, w_data};
   assign {if3.inputs, if3.w_data} = {inputs_v, w_data};

   dense_layer_mac #(.N_OUT(4), .N_IN(N_IN), .LANES(2), .DATA_W(DW), .FRAC(16), .ACT(0))
      u0 (.CLK(CLK), .reset(reset), .bus(if0), .state_dbg(st0));
   dense_layer_mac #(.N_OUT(4), .N_IN(N_IN), .LANES(2), .DATA_W(DW), .FRAC(16), .ACT(1))
      u1 (.CLK(CLK), .reset(reset), .bus(if1), .state_dbg(st1));
   dense_layer_mac #(.N_OUT(4), .N_IN(N_IN), .LANES(2), .DATA_W(DW), .FRAC(16), .ACT(2))
      u2 (.CLK(CLK), .reset(reset), .bus(if2), .state_dbg(st2));
   dense_layer_mac #(.N_OUT(3), .N_IN(N_IN), .LANES(2), .DATA_W(DW), .FRAC(16), .ACT(0))
      u3 (.CLK(CLK), .reset(reset), .bus(if3), .state_dbg(st3));

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [5:0] a, input logic [5:0] a3, input logic we3, input logic [DW-1:0] d);
      @(negedge CLK);
      w_addr = a; w_addr3 = a3; w_data = d; w_we = 1'b1; w_we3 = we3;
      @(negedge CLK);
      w_we = 1'b0; w_we3 = 1'b0;
   endtask

   // Fills every weight with wv and every bias with bv on all instances.
   task automatic load(input logic [DW-1:0] wv, input logic [DW-1:0] bv);
      for (int k = 0; k < 44; k++) begin
         if (k < 40) wr(6'(k), 6'(k), (k < 30), wv);
         else        wr(6'(k), 6'(k - 10), (k < 43), bv);
      end
   endtask

   // Presents one vector, optionally stalls or strobes a write mid-run, and
   // returns the accept-to-out_valid edge count and end_layer pulses seen.
   task automatic run_vec(input logic [DW-1:0] xv, input int stall_at, input int stall_len,
                          input int wr_at, output int lat, output int pulses);
      lat = -1;
      pulses = 0;
      @(negedge CLK);
      inputs_v = {N_IN{xv}};
      in_valid = 1'b1;
      @(negedge CLK);
      in_valid = 1'b0;
      check("in_ready_busy", DW'(if0.in_ready), 32'd0);
      for (int e = 1; e <= 200 && lat < 0; e++) begin
         enable = !(e > stall_at && e <= stall_at + stall_len);
         w_we   = (e == wr_at);
         w_we3  = (e == wr_at);
         @(negedge CLK);
         if (if0.end_layer) pulses++;
         if (if0.out_valid) lat = e;
      end
      enable = 1'b1; w_we = 1'b0; w_we3 = 1'b0;
      check("u3_out_valid", DW'(if3.out_valid), 32'd1);
   endtask

   task automatic drain(input string tag, input int pulses);
      @(negedge CLK);
      if (if0.end_layer) pulses++;
      check({tag, " end_layer_pulses"}, DW'(pulses), 32'd1);
      check({tag, " out_valid_hold"}, DW'(if0.out_valid), 32'd1);
      out_ready = 1'b1;
      @(negedge CLK);
      out_ready = 1'b0;
      check({tag, " out_valid_clear"}, DW'(if0.out_valid), 32'd0);
      check({tag, " in_ready_back"}, DW'(if0.in_ready), 32'd1);
   endtask

   task automatic check_outs(input string tag, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                             input logic [DW-1:0] e2);
      for (int n = 0; n < 4; n++) begin
         check($sformatf("%s act0 out[%0d]", tag, n), if0.out[n], e0);
         check($sformatf("%s act1 out[%0d]", tag, n), if1.out[n], e1);
         check($sformatf("%s act2 out[%0d]", tag, n), if2.out[n], e2);
      end
      for (int n = 0; n < 3; n++)
         check($sformatf("%s part out[%0d]", tag, n), if3.out[n], e0);
   endtask

   initial begin
      int lat, pulses;
      //         weight        bias          input         act0          act1          act2
      tbl[0] = '{32'h0001_0000, 32'h0000_0000, 32'h0001_0000, 32'h000A_0000, 32'h000A_0000, 32'h000A_0000};
      tbl[1] = '{32'h0001_0000, 32'hFFEC_0000, 32'h0001_0000, 32'hFFF6_0000, 32'h0000_0000, 32'hFFFE_C000};
      tbl[2] = '{32'h7FFF_0000, 32'h0000_0000, 32'h7FFF_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
      tbl[3] = '{32'h7FFF_0000, 32'h0000_0000, 32'h8001_0000, 32'h8000_0000, 32'h0000_0000, 32'hF000_0000};
      tbl[4] = '{32'h0000_8000, 32'h0001_0000, 32'h0003_0000, 32'h0010_0000, 32'h0010_0000, 32'h0010_0000};
      tbl[5] = '{32'h0001_8000, 32'h0002_0000, 32'hFFFF_0000, 32'hFFF3_0000, 32'h0000_0000, 32'hFFFE_6000};
      tbl[6] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_4000, 32'hFFFF_FFFD, 32'h0000_0000, 32'hFFFF_FFFF};

      reset = 1'b0; enable = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      w_we = 1'b0; w_we3 = 1'b0; w_addr = '0; w_addr3 = '0; w_data = '0; inputs_v = '0;
      repeat (3) @(negedge CLK);
      check("rst out[0]", if0.out[0], 32'd0);
      check("rst out_valid", DW'(if0.out_valid), 32'd0);
      check("rst end_layer", DW'(if0.end_layer), 32'd0);
      check("rst state", DW'(st0), 32'd0);
      reset = 1'b1;
      @(negedge CLK);
      check("in_ready_disabled", DW'(if0.in_ready), 32'd0);
      enable = 1'b1;
      #1;
      check("in_ready_enabled", DW'(if0.in_ready), 32'd1);

      for (int t = 0; t < 7; t++) begin
         load(tbl[t].w, tbl[t].b);
         run_vec(tbl[t].x, 0, 0, 0, lat, pulses);
         check($sformatf("v%0d latency", t), DW'(lat), 32'd22);
         check_outs($sformatf("v%0d", t), tbl[t].e0, tbl[t].e1, tbl[t].e2);
         drain($sformatf("v%0d", t), pulses);
      end

      // Seven stalled cycles early in MAC push the result out to edge 29.
      load(32'h0001_0000, 32'h0);
      run_vec(32'h0001_0000, 3, 7, 0, lat, pulses);
      check("stall latency", DW'(lat), 32'd29);
      check_outs("stall", 32'h000A_0000, 32'h000A_0000, 32'h000A_0000);
      drain("stall", pulses);

      // Reset in the middle of MAC drops the result but keeps the weights.
      @(negedge CLK);
      inputs_v = {N_IN{32'h0001_0000}};
      in_valid = 1'b1;
      @(negedge CLK);
      in_valid = 1'b0;
      repeat (5) @(negedge CLK);
      check("mid state", DW'(st0), 32'd1);
      reset = 1'b0;
      #1;
      check("mid_rst out[0]", if0.out[0], 32'd0);
      check("mid_rst out[3]", if0.out[3], 32'd0);
      check("mid_rst out_valid", DW'(if0.out_valid), 32'd0);
      check("mid_rst in_ready", DW'(if0.in_ready), 32'd1);
      check("mid_rst state", DW'(st0), 32'd0);
      @(negedge CLK);
      reset = 1'b1;
      run_vec(32'h0001_0000, 0, 0, 0, lat, pulses);
      check("rerun latency", DW'(lat), 32'd22);
      check_outs("rerun", 32'h000A_0000, 32'h000A_0000, 32'h000A_0000);
      drain("rerun", pulses);

      // A weight write while busy must be dropped.
      w_addr = 6'd0; w_addr3 = 6'd0; w_data = 32'h0002_0000;
      run_vec(32'h0001_0000, 0, 0, 4, lat, pulses);
      check("busy_wr out[0]", if0.out[0], 32'h000A_0000);
      check("busy_wr part out[0]", if3.out[0], 32'h000A_0000);
      drain("busy_wr", pulses);

      wr(6'd0, 6'd0, 1'b1, 32'h0002_0000);
      run_vec(32'h0001_0000, 0, 0, 0, lat, pulses);
      check("idle_wr out[0]", if0.out[0], 32'h000B_0000);
      check("idle_wr out[1]", if0.out[1], 32'h000A_0000);
      check("idle_wr act1 out[0]", if1.out[0], 32'h000B_0000);
      check("idle_wr part out[0]", if3.out[0], 32'h000B_0000);
      drain("idle_wr", pulses);

      wr(6'd44, 6'd44, 1'b1, 32'h7FFF_0000);
      run_vec(32'h0001_0000, 0, 0, 0, lat, pulses);
      check("oob_wr out[0]", if0.out[0], 32'h000B_0000);
      check("oob_wr out[3]", if0.out[3], 32'h000A_0000);
      check("oob_wr part out[2]", if3.out[2], 32'h000A_0000);
      drain("oob_wr", pulses);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
